// File: rtl/complex_bicg_sequencer.sv
// complex_bicg_sequencer
// Iteration controller for the complex BiCG datapath. It steps through the
// solver phases with one explicit state machine, drives level run bits into
// the vector/matrix/division units and watches their finish flags. It paces
// chunk reads during the two dot-product phases, counts iterations, and stops
// on tolerance, on the iteration limit, or on abort.
module complex_bicg_sequencer #(
  parameter int          element_width = 64,
  parameter int          no_of_units   = 8,
  parameter int          iter_width    = 16,
  parameter logic [31:0] tol_default   = 32'h283424DC
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     go,
  input  logic                     abort,
  input  logic [31:0]              total,
  input  logic [iter_width-1:0]    max_iter,
  input  logic                     tol_override,
  input  logic [31:0]              tol_in,
  input  logic [element_width-1:0] vxv1_result,
  input  logic [element_width-1:0] div_tol_result,
  input  logic [6:0]               finish,
  input  logic                     unit_ready,
  output logic [6:0]               phase_run,
  output logic                     rd_strobe,
  output logic [31:0]              chunk_count,
  output logic [iter_width-1:0]    iter_count,
  output logic [element_width-1:0] bnorm,
  output logic                     busy,
  output logic                     done,
  output logic                     converged,
  output logic                     timeout
);

  localparam int CHUNK_SHIFT = $clog2(no_of_units);

  typedef enum logic [3:0] {
    S_IDLE,
    S_RHO,
    S_MXV,
    S_ALPHA,
    S_UPD_XR,
    S_NORM,
    S_TOL_BETA,
    S_CHECK,
    S_P_UPD,
    S_DONE
  } state_t;

  state_t state_reg;
  state_t state_next;

  logic                   bnorm_valid_reg;
  logic [31:0]            chunk_limit;
  logic [31:0]            tol_sel;
  logic [31:0]            ratio_hi;
  logic                   abort_hit;
  logic                   go_start;
  logic                   tol_hit;
  logic                   limit_hit;
  logic                   state_change;
  logic                   chunk_state;
  logic                   chunk_state_next;
  logic [iter_width:0]    iter_plus_one;
  logic [iter_width-1:0]  iter_inc;

  // Only the upper 32 bits of the ratio take part in the tolerance compare.
  logic unused_ratio_lo;
  assign unused_ratio_lo = ^div_tol_result[element_width-33:0];

  // Number of whole chunks in the vector; a partial tail chunk is not read.
  assign chunk_limit = total >> CHUNK_SHIFT;

  assign tol_sel   = tol_override ? tol_in : tol_default;
  assign ratio_hi  = div_tol_result[element_width-1 -: 32];
  assign tol_hit   = (ratio_hi <= tol_sel);

  // Extra bit keeps iter_count+1 from wrapping onto a small max_iter value.
  assign iter_plus_one = {1'b0, iter_count} + (iter_width+1)'(1);
  assign limit_hit     = (max_iter != '0) && (iter_plus_one == {1'b0, max_iter});
  assign iter_inc      = (&iter_count) ? iter_count : iter_plus_one[iter_width-1:0];

  assign abort_hit = abort && (state_reg != S_IDLE);
  assign go_start  = go && (state_reg == S_IDLE);

  assign state_change     = (state_next != state_reg);
  assign chunk_state      = (state_reg == S_RHO) || (state_reg == S_NORM);
  assign chunk_state_next = (state_next == S_RHO) || (state_next == S_NORM);

  // One-hot run level for a state; zero for states that run no unit.
  function automatic logic [6:0] run_of(input state_t s);
    case (s)
      S_RHO:      run_of = 7'b000_0001;
      S_MXV:      run_of = 7'b000_0010;
      S_ALPHA:    run_of = 7'b000_0100;
      S_UPD_XR:   run_of = 7'b000_1000;
      S_NORM:     run_of = 7'b001_0000;
      S_TOL_BETA: run_of = 7'b010_0000;
      S_P_UPD:    run_of = 7'b100_0000;
      default:    run_of = 7'b000_0000;
    endcase
  endfunction

  // Next-state decode; abort beats every finish flag.
  always_comb begin
    state_next = state_reg;
    if (abort_hit) begin
      state_next = S_IDLE;
    end else begin
      case (state_reg)
        S_IDLE:     if (go)        state_next = S_RHO;
        S_RHO:      if (finish[0]) state_next = S_MXV;
        S_MXV:      if (finish[1]) state_next = S_ALPHA;
        S_ALPHA:    if (finish[2]) state_next = S_UPD_XR;
        S_UPD_XR:   if (finish[3]) state_next = S_NORM;
        S_NORM:     if (finish[4]) state_next = S_TOL_BETA;
        S_TOL_BETA: if (finish[5]) state_next = S_CHECK;
        S_CHECK:    state_next = (tol_hit || limit_hit) ? S_DONE : S_P_UPD;
        S_P_UPD:    if (finish[6]) state_next = S_RHO;
        S_DONE:     state_next = S_IDLE;
        default:    state_next = S_IDLE;
      endcase
    end
  end

  // State register with registered run bits and handshake status.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg <= S_IDLE;
      phase_run <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      state_reg <= state_next;
      phase_run <= run_of(state_next);
      busy      <= (state_next != S_IDLE);
      done      <= (state_next == S_DONE);
    end
  end

  // Chunk-read pacing: first strobe on entry, then one per ready cycle up to N.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_strobe   <= 1'b0;
      chunk_count <= '0;
    end else if (state_change) begin
      rd_strobe   <= chunk_state_next && (chunk_limit != 32'd0);
      chunk_count <= (chunk_state_next && (chunk_limit != 32'd0)) ? 32'd1 : 32'd0;
    end else if (chunk_state && unit_ready && (chunk_count < chunk_limit)) begin
      rd_strobe   <= 1'b1;
      chunk_count <= chunk_count + 32'd1;
    end else begin
      rd_strobe   <= 1'b0;
    end
  end

  // Iteration count, initial-norm latch and convergence/limit flags.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      iter_count      <= '0;
      bnorm           <= '0;
      bnorm_valid_reg <= 1'b0;
      converged       <= 1'b0;
      timeout         <= 1'b0;
    end else if (go_start) begin
      iter_count      <= '0;
      bnorm_valid_reg <= 1'b0;
      converged       <= 1'b0;
      timeout         <= 1'b0;
    end else if (!abort_hit) begin
      case (state_reg)
        S_RHO: begin
          if (finish[0] && !bnorm_valid_reg) begin
            bnorm           <= vxv1_result;
            bnorm_valid_reg <= 1'b1;
          end
        end
        S_CHECK: begin
          if (tol_hit) begin
            converged <= 1'b1;
          end else if (limit_hit) begin
            timeout    <= 1'b1;
            iter_count <= iter_inc;
          end
        end
        S_P_UPD: begin
          if (finish[6]) iter_count <= iter_inc;
        end
        default: ;
      endcase
    end
  end

endmodule
